// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding,
// load/store size codes and the access-legality decode.
package unified_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_F_ISSUE = 3'd1,
    S_F_RESP  = 3'd2,
    S_D_ISSUE = 3'd3,
    S_D_RESP  = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when a data access must be refused: misaligned half/word, an
  // unknown size code, or an unsigned size code used with a store.
  function automatic logic d_access_bad(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_lsu_align.sv
// Combinational lane logic: store byte-enables and lane replication, and
// load byte/half extraction with sign or zero extension.
module unified_mem_arbiter_lsu_align
  import unified_mem_arbiter_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: enable only the addressed lanes, replicate data into all lanes
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W:    o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  // Load side: pick the addressed byte/half and extend it to 32 bits
  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'h0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'h0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a load/store port. One access in flight at a time; contested grants
// alternate between the two classes.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            r_state;
  logic              r_last_d;   // 1: data won the most recent contested grant
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_bad;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_d_err;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_decide;
  logic              w_f_pend;
  logic              w_d_pend;
  logic              w_grant_f;
  logic              w_grant_d;
  logic              w_d_bad;
  logic              w_f_issue;
  logic              w_d_issue;
  logic [3:0]        w_be;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_ld_data;

  unified_mem_arbiter_lsu_align u_lsu_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_st_wdata),
    .o_ldata  (w_ld_data)
  );

  // Grant decision; a request still high while its own ack is being formed
  // or is on the wire is the one just served, so it does not count as pending
  always_comb begin
    w_decide  = (r_state == S_IDLE) || (r_state == S_F_RESP) || (r_state == S_D_RESP);
    w_f_pend  = if_req && !r_if_ack && (r_state != S_F_RESP);
    w_d_pend  = d_req && !r_d_ack && (r_state != S_D_RESP);
    w_grant_d = w_decide && w_d_pend && (!w_f_pend || !r_last_d);
    w_grant_f = w_decide && w_f_pend && !w_grant_d;
    w_d_bad   = d_access_bad(d_we, d_funct3, d_addr[1:0]);
  end

  // Memory strobes decoded from state and the latched request only
  always_comb begin
    w_f_issue = (r_state == S_F_ISSUE);
    w_d_issue = (r_state == S_D_ISSUE);
    mem_re    = w_f_issue || (w_d_issue && !r_we);
    mem_we    = w_d_issue && r_we;
    mem_be    = mem_we ? w_be : 4'b0000;
    mem_wdata = mem_we ? w_st_wdata : 32'h0;
    mem_addr  = (w_f_issue || w_d_issue) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  end

  assign if_ack   = r_if_ack;
  assign if_rdata = r_if_rdata;
  assign d_ack    = r_d_ack;
  assign d_err    = r_d_err;
  assign d_rdata  = r_d_rdata;

  // Arbiter FSM with request latching and registered ack/read-data outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_wdata    <= 32'h0;
      r_bad      <= 1'b0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        S_F_ISSUE: r_state <= S_F_RESP;
        S_D_ISSUE: r_state <= S_D_RESP;
        default: begin
          if (r_state == S_F_RESP) begin
            r_if_ack   <= 1'b1;
            r_if_rdata <= mem_rdata;
          end
          if (r_state == S_D_RESP) begin
            r_d_ack <= 1'b1;
            r_d_err <= r_bad;
            if (!r_bad && !r_we) r_d_rdata <= w_ld_data;
          end
          // Priority only flips when both classes actually contend
          if (w_f_pend && w_d_pend) r_last_d <= w_grant_d;
          if (w_grant_d) begin
            r_addr   <= d_addr;
            r_we     <= d_we;
            r_funct3 <= d_funct3;
            r_wdata  <= d_wdata;
            r_bad    <= w_d_bad;
            r_state  <= w_d_bad ? S_D_RESP : S_D_ISSUE;
          end else if (w_grant_f) begin
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_bad   <= 1'b0;
            r_state <= S_F_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter with a small memory model.
module tb_unified_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];

  int          re_cnt, we_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: read data one cycle after mem_re, byte-lane writes
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'h00500093;
      mem[8]    <= 32'h80FF7F01;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {24'h0, if_ack, d_ack, d_err, mem_re, mem_we, mem_be[2:0]}, 32'h0);
    chk({tag, "_be3"}, {31'h0, mem_be[3]}, 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic issue_f(input logic [31:0] addr, input logic [31:0] exp_rdata, input int lat);
    exp_t e;
    if_addr = addr;
    if_req  = 1'b1;
    e = '{rdata: exp_rdata, err: 1'b0, lat: lat, t0: cyc};
    fq.push_back(e);
  endtask

  task automatic issue_d(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic err, input int lat);
    exp_t e;
    d_we     = we;
    d_funct3 = f3;
    d_addr   = addr;
    d_wdata  = wdata;
    d_req    = 1'b1;
    e = '{rdata: exp_rdata, err: err, lat: lat, t0: cyc};
    dq.push_back(e);
  endtask

  // Run until every raised request is acked, comparing each ack against the scoreboard
  task automatic drain(input string tag);
    exp_t e;
    re_cnt = 0;
    we_cnt = 0;
    for (int n = 0; n < 20 && (if_req || d_req); n++) begin
      @(negedge clk);
      if (mem_re) begin re_cnt++; cap_addr = mem_addr; end
      if (mem_we) begin we_cnt++; cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; end
      if (if_ack && d_ack) chk({tag, "_ack_overlap"}, {31'h0, if_ack & d_ack}, 32'h0);
      if (if_ack) begin
        chk({tag, "_if_ack_expected"}, {31'h0, fq.size() != 0}, 32'h1);
        if (fq.size() != 0) begin
          e = fq.pop_front();
          chk({tag, "_if_rdata"}, if_rdata, e.rdata);
          chk({tag, "_if_lat"}, cyc - e.t0, e.lat);
        end
        if_req = 1'b0;
      end
      if (d_ack) begin
        chk({tag, "_d_ack_expected"}, {31'h0, dq.size() != 0}, 32'h1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk({tag, "_d_rdata"}, d_rdata, e.rdata);
          chk({tag, "_d_err"}, {31'h0, d_err}, {31'h0, e.err});
          chk({tag, "_d_lat"}, cyc - e.t0, e.lat);
        end
        d_req = 1'b0;
      end
    end
    if (if_req || d_req) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed=no ack expected=ack within 20 cycles", tag);
      if_req = 1'b0;
      d_req  = 1'b0;
      fq.delete();
      dq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int waited;
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = '0; d_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Lone fetch
    issue_f(32'h10, 32'h00500093, 3);
    drain("fetch");
    chk("fetch_mem_addr", cap_addr, 32'h10);
    chk("fetch_re_cnt", re_cnt, 1);

    // Contention after reset: data first, fetch two cycles later
    issue_d(1'b0, LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 3);
    issue_f(32'h10, 32'h00500093, 5);
    drain("pair1");
    // Contention again: fetch first this time
    issue_f(32'h10, 32'h00500093, 3);
    issue_d(1'b0, LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 5);
    drain("pair2");

    // Loads with extraction/extension
    issue_d(1'b0, LB, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 3);  drain("lb");
    chk("lb_mem_addr", cap_addr, 32'h20);
    issue_d(1'b0, LBU, 32'h23, 32'h0, 32'h00000080, 1'b0, 3); drain("lbu");
    issue_d(1'b0, LH, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 3);  drain("lh");
    issue_d(1'b0, LHU, 32'h22, 32'h0, 32'h000080FF, 1'b0, 3); drain("lhu");
    issue_d(1'b0, LB, 32'h20, 32'h0, 32'h00000001, 1'b0, 3);  drain("lb0");
    issue_d(1'b0, LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 3);  drain("lw");

    // Stores: lane enables, lane data, d_rdata untouched
    issue_d(1'b1, LH, 32'h12, 32'h0000BEEF, 32'h80FF7F01, 1'b0, 3); drain("sh");
    chk("sh_we_cnt", we_cnt, 1);
    chk("sh_re_cnt", re_cnt, 0);
    chk("sh_be", {28'h0, cap_be}, 32'h0000000C);
    chk("sh_wdata_hi", {16'h0, cap_wdata[31:16]}, 32'h0000BEEF);
    chk("sh_mem_addr", cap_addr, 32'h10);
    issue_d(1'b0, LW, 32'h10, 32'h0, 32'hBEEF0093, 1'b0, 3); drain("lw_after_sh");
    issue_d(1'b1, LB, 32'h11, 32'h123456AA, 32'hBEEF0093, 1'b0, 3); drain("sb");
    chk("sb_be", {28'h0, cap_be}, 32'h00000002);
    chk("sb_wdata_lane1", {24'h0, cap_wdata[15:8]}, 32'h000000AA);
    issue_d(1'b0, LBU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3); drain("lbu_after_sb");
    issue_d(1'b0, LW, 32'h10, 32'h0, 32'hBEEFAA93, 1'b0, 3);  drain("lw_after_sb");

    // Refused accesses: error ack two cycles after the request, no strobes
    issue_d(1'b0, LW, 32'h21, 32'h0, 32'hBEEFAA93, 1'b1, 2); drain("lw_mis");
    chk("lw_mis_strobes", re_cnt + we_cnt, 0);
    issue_d(1'b0, LH, 32'h23, 32'h0, 32'hBEEFAA93, 1'b1, 2); drain("lh_mis");
    chk("lh_mis_strobes", re_cnt + we_cnt, 0);
    issue_d(1'b0, 3'b011, 32'h20, 32'h0, 32'hBEEFAA93, 1'b1, 2); drain("f3_bad");
    chk("f3_bad_strobes", re_cnt + we_cnt, 0);
    issue_d(1'b1, LW, 32'h22, 32'h55555555, 32'hBEEFAA93, 1'b1, 2); drain("sw_mis");
    chk("sw_mis_strobes", re_cnt + we_cnt, 0);
    issue_d(1'b1, LBU, 32'h20, 32'h55555555, 32'hBEEFAA93, 1'b1, 2); drain("sbu_bad");
    chk("sbu_bad_strobes", re_cnt + we_cnt, 0);

    // Reset while the data access is in its issue cycle
    d_we = 1'b0; d_funct3 = LW; d_addr = 32'h20; d_wdata = 32'h0; d_req = 1'b1;
    waited = 0;
    while (!mem_re && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_mid_reached_issue", {31'h0, mem_re}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_mid");
    d_req = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ack", {30'h0, d_ack, if_ack}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
